// File: rtl/timer_counter_if.sv
// CPU data-bus view of the timer: byte-addressed writes with lane enables, combinational read-back.
// The core drives address/data as master; the timer drives rdata and irq as slave.
interface timer_counter_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, byteen, wdata, input rdata, irq);
  modport slave  (input addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT words, irq N+3 cycles after enable.
// Reads are combinational, writes take effect on the next edge; the bus is never stalled.
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic       hit;
  logic [1:0] sel;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       en;
  logic       reload;
  logic       int_fire;
  logic       unused_ok;

  assign hit       = (bus.addr[31:4] == BASE[31:4]);
  assign sel       = bus.addr[3:2];
  assign wr_ctrl   = hit && (|bus.byteen) && (sel == 2'd0);
  assign wr_preset = hit && (|bus.byteen) && (sel == 2'd1);
  assign en        = ctrl[0];
  assign reload    = (ctrl[2:1] == 2'b01);
  assign int_fire  = (state == INT) && en;
  assign unused_ok = &{1'b0, bus.addr[1:0]};

  assign bus.irq = irq_flag & ctrl[3];

  always_comb begin
    bus.rdata = 32'd0;
    if (hit) begin
      case (sel)
        2'd0:    bus.rdata = {28'd0, ctrl};
        2'd1:    bus.rdata = preset;
        2'd2:    bus.rdata = count;
        default: bus.rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_preset && bus.byteen[i])
          preset[8*i +: 8] <= bus.wdata[8*i +: 8];
      end

      // A bus write to CTRL overrides the one-shot hardware clear of en.
      if (wr_ctrl && bus.byteen[0])
        ctrl <= bus.wdata[3:0];
      else if (int_fire && !reload)
        ctrl[0] <= 1'b0;

      // Setting on expiry beats any clear in the same cycle.
      if (int_fire)
        irq_flag <= 1'b1;
      else if (irq_flag && reload)
        irq_flag <= 1'b0;
      else if (wr_ctrl || wr_preset)
        irq_flag <= 1'b0;

      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            count <= preset;
            state <= CNT;
          end
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= 32'd0;
            state <= INT;
          end
        end
        INT:     state <= (en && reload) ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: stimulus pushes expected {rdata, irq} per read cycle,
// a negedge monitor pops and compares whenever a check cycle is presented.
module tb_timer_counter;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSV  = BASE + 32'hC;
  localparam logic [31:0] A_OUT  = BASE + 32'h10;

  typedef struct {
    int          id;
    logic [31:0] rd;
    logic        ir;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic chk_vld = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   nid = 0;
  exp_t q[$];
  exp_t e;

  timer_counter_if bus ();

  timer_counter #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_vld) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: check presented with no expectation queued");
      end else begin
        e = q.pop_front();
        total += 2;
        if (bus.rdata !== e.rd) begin
          bad++;
          $display("FAIL chk%0d rdata: got=%h want=%h", e.id, bus.rdata, e.rd);
        end
        if (bus.irq !== e.ir) begin
          bad++;
          $display("FAIL chk%0d irq: got=%b want=%b", e.id, bus.irq, e.ir);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.addr   = a;
    bus.byteen = be;
    bus.wdata  = d;
    tick();
    bus.byteen = 4'd0;
    bus.wdata  = 32'd0;
  endtask

  task automatic chk(input logic [31:0] a, input logic [31:0] rd, input logic ir);
    bus.addr   = a;
    bus.byteen = 4'd0;
    bus.wdata  = 32'd0;
    q.push_back('{nid, rd, ir});
    nid++;
    chk_vld = 1'b1;
    tick();
    chk_vld = 1'b0;
  endtask

  // Auto-reload with preset 3: period LOAD(0),3,2,1,INT(0); irq visible during each LOAD after the first.
  function automatic logic [31:0] ar_count(input int i);
    case (i % 5)
      1:       return 32'd3;
      2:       return 32'd2;
      3:       return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    reset      = 1'b1;
    bus.addr   = 32'd0;
    bus.byteen = 4'd0;
    bus.wdata  = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk(A_CTRL, 32'd0, 1'b0);
    chk(A_PRE,  32'd0, 1'b0);
    chk(A_CNT,  32'd0, 1'b0);

    // One-shot, preset 5, masked-in irq
    wr(A_PRE, 4'hF, 32'd5);
    wr(A_CTRL, 4'hF, 32'h9);
    chk(A_CNT, 32'd0, 1'b0);
    chk(A_CNT, 32'd0, 1'b0);
    for (int k = 5; k >= 0; k--) chk(A_CNT, 32'(k), 1'b0);
    chk(A_CTRL, 32'h8, 1'b1);
    chk(A_CTRL, 32'h8, 1'b1);
    wr(A_CTRL, 4'hF, 32'h8);
    chk(A_CTRL, 32'h8, 1'b0);

    // Auto-reload, preset 3
    wr(A_PRE, 4'hF, 32'd3);
    wr(A_CTRL, 4'hF, 32'hB);
    chk(A_CNT, 32'd0, 1'b0);
    for (int i = 0; i < 16; i++) chk(A_CNT, ar_count(i), (i % 5 == 0) && (i >= 5));
    wr(A_CTRL, 4'hF, 32'h0);

    // Masked expiry, then unmask: flag cleared by the write, irq only on the next expiry
    wr(A_PRE, 4'hF, 32'd2);
    wr(A_CTRL, 4'hF, 32'h1);
    tick();
    tick();
    chk(A_CNT, 32'd2, 1'b0);
    chk(A_CNT, 32'd1, 1'b0);
    chk(A_CNT, 32'd0, 1'b0);
    chk(A_CTRL, 32'h0, 1'b0);
    chk(A_CNT, 32'd0, 1'b0);
    wr(A_CTRL, 4'b0001, 32'h9);
    chk(A_CNT, 32'd0, 1'b0);
    chk(A_CNT, 32'd0, 1'b0);
    chk(A_CNT, 32'd2, 1'b0);
    chk(A_CNT, 32'd1, 1'b0);
    chk(A_CNT, 32'd0, 1'b0);
    chk(A_CNT, 32'd0, 1'b1);
    wr(A_CTRL, 4'hF, 32'h0);
    chk(A_CTRL, 32'h0, 1'b0);

    // Partial writes, read-only COUNT, reserved and out-of-window addresses
    wr(A_PRE, 4'hF, 32'hAABB_CCDD);
    wr(A_PRE, 4'b0100, 32'h0011_0000);
    chk(A_PRE, 32'hAA11_CCDD, 1'b0);
    chk(A_PRE + 32'h2, 32'hAA11_CCDD, 1'b0);
    wr(A_CNT, 4'hF, 32'h1234_5678);
    chk(A_CNT, 32'd0, 1'b0);
    wr(A_RSV, 4'hF, 32'hFFFF_FFFF);
    chk(A_RSV, 32'd0, 1'b0);
    wr(A_OUT, 4'hF, 32'hFFFF_FFFF);
    chk(A_OUT, 32'd0, 1'b0);
    chk(A_PRE, 32'hAA11_CCDD, 1'b0);
    chk(A_CTRL, 32'h0, 1'b0);
    chk(A_CNT, 32'd0, 1'b0);

    // Abort at count 50, re-enable reloads 100, then reset mid-count
    wr(A_PRE, 4'hF, 32'd100);
    wr(A_CTRL, 4'hF, 32'h9);
    tick();
    tick();
    chk(A_CNT, 32'd100, 1'b0);
    repeat (47) tick();
    chk(A_CNT, 32'd52, 1'b0);
    wr(A_CTRL, 4'hF, 32'h8);
    chk(A_CNT, 32'd50, 1'b0);
    chk(A_CNT, 32'd50, 1'b0);
    chk(A_CNT, 32'd50, 1'b0);
    chk(A_CTRL, 32'h8, 1'b0);
    wr(A_CTRL, 4'hF, 32'h9);
    chk(A_CNT, 32'd50, 1'b0);
    chk(A_CNT, 32'd50, 1'b0);
    chk(A_CNT, 32'd100, 1'b0);
    chk(A_CNT, 32'd99, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk(A_CNT, 32'd0, 1'b0);
    chk(A_PRE, 32'd0, 1'b0);
    chk(A_CTRL, 32'd0, 1'b0);
    chk(A_CNT, 32'd0, 1'b0);

    tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
